// File: rtl/tb_qspi_mem.sv
// Cycle-accurate QSPI memory emulator: oversamples the bus on clk and serves
// NUM_CS independent byte-wide banks with quad read (0x0B) and quad write (0x02).
//
// state  | meaning
// IDLE   | all CS high, waiting for exactly one CS low
// CMD    | collecting the two command nibbles
// ADDR   | collecting six address nibbles
// DUMMY  | counting dummy nibbles before read data
// RD     | driving read data on spi_clk falling edges
// WR     | assembling bytes on spi_clk rising edges
// IGNORE | bus activity discarded until all CS high
module tb_qspi_mem #(
  parameter int                NUM_CS        = 3,
  parameter int                DEPTH_LOG2    = 16,
  parameter int                DUMMY_NIBBLES = 4,
  parameter logic [NUM_CS-1:0] WRITABLE      = 3'b110,
  localparam int               BW            = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic [NUM_CS-1:0]     spi_cs_n,
  input  logic [3:0]            spi_d_in,
  output logic [3:0]            spi_d_out,
  output logic [3:0]            spi_d_oe,
  input  logic                  ld_en,
  input  logic [BW-1:0]         ld_bank,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [7:0]            ld_data,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGNORE
  } state_t;

  logic [2:0]            clk_sync;
  logic [NUM_CS-1:0]     cs_s1, cs_s2, cs_s3;
  logic [3:0]            d_s1, d_s2, d_s3;
  logic                  rise_ev, fall_ev;

  state_t                state;
  logic [BW-1:0]         bank;
  logic [BW-1:0]         sel_bank;
  logic [DEPTH_LOG2-1:0] addr;
  logic [19:0]           addr_sr;
  logic [7:0]            cnt;
  logic                  half;
  logic [3:0]            hi_nib;
  logic                  is_wr;
  logic                  armed;
  logic                  cs_all_high;
  logic                  one_cs_low;
  logic                  commit;
  logic [7:0]            rd_byte;

  logic [7:0] mem [NUM_CS][DEPTH];

  // Synchronisers carry no reset so the pipeline always reflects the real pins.
  always_ff @(posedge clk) begin
    clk_sync <= {clk_sync[1:0], spi_clk};
    cs_s1    <= spi_cs_n;
    cs_s2    <= cs_s1;
    cs_s3    <= cs_s2;
    d_s1     <= spi_d_in;
    d_s2     <= d_s1;
    d_s3     <= d_s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_ev <= 1'b0;
      fall_ev <= 1'b0;
    end else begin
      rise_ev <= clk_sync[1] & ~clk_sync[2];
      fall_ev <= ~clk_sync[1] & clk_sync[2];
    end
  end

  assign cs_all_high = &cs_s3;
  assign one_cs_low  = ($countones(~cs_s3) == 1);

  always_comb begin
    sel_bank = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!cs_s3[i]) sel_bank = BW'(i);
    end
  end

  assign rd_byte = mem[bank][addr];
  assign commit  = !rst && !cs_all_high && (state == S_WR) && rise_ev && half && WRITABLE[bank];

  // Backdoor write is placed last so it wins a same-cycle collision.
  always_ff @(posedge clk) begin
    if (commit) mem[bank][addr] <= {hi_nib, d_s3};
    if (ld_en)  mem[ld_bank][ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      bank      <= '0;
      addr      <= '0;
      addr_sr   <= '0;
      cnt       <= '0;
      half      <= 1'b0;
      hi_nib    <= '0;
      is_wr     <= 1'b0;
      spi_d_out <= 4'h0;
      spi_d_oe  <= 4'h0;
      busy      <= 1'b0;
    end else begin
      busy <= ~cs_all_high;
      if (cs_all_high) begin
        armed     <= 1'b1;
        state     <= S_IDLE;
        cnt       <= '0;
        half      <= 1'b0;
        spi_d_out <= 4'h0;
        spi_d_oe  <= 4'h0;
      end else begin
        case (state)
          S_IDLE: begin
            // Unarmed after reset: a transaction already in flight is skipped.
            if (armed) begin
              if (one_cs_low) begin
                state <= S_CMD;
                bank  <= sel_bank;
                cnt   <= '0;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_CMD: begin
            if (rise_ev) begin
              if (cnt == 8'd0) begin
                hi_nib <= d_s3;
                cnt    <= 8'd1;
              end else begin
                cnt <= '0;
                case ({hi_nib, d_s3})
                  8'h0B: begin is_wr <= 1'b0; state <= S_ADDR; end
                  8'h02: begin is_wr <= 1'b1; state <= S_ADDR; end
                  default: state <= S_IGNORE;
                endcase
              end
            end
          end
          S_ADDR: begin
            if (rise_ev) begin
              addr_sr <= {addr_sr[15:0], d_s3};
              if (cnt == 8'd5) begin
                addr <= DEPTH_LOG2'({addr_sr, d_s3});
                cnt  <= '0;
                half <= 1'b0;
                if (is_wr)                   state <= S_WR;
                else if (DUMMY_NIBBLES == 0) state <= S_RD;
                else                         state <= S_DUMMY;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_DUMMY: begin
            if (rise_ev) begin
              if (cnt == 8'(DUMMY_NIBBLES - 1)) begin
                cnt   <= '0;
                state <= S_RD;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_RD: begin
            if (fall_ev) begin
              spi_d_oe <= 4'hF;
              if (!half) begin
                spi_d_out <= rd_byte[7:4];
                half      <= 1'b1;
              end else begin
                spi_d_out <= rd_byte[3:0];
                half      <= 1'b0;
                addr      <= addr + 1'b1;
              end
            end
          end
          S_WR: begin
            if (rise_ev) begin
              if (!half) begin
                hi_nib <= d_s3;
                half   <= 1'b1;
              end else begin
                half <= 1'b0;
                addr <= addr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tb_qspi_mem.sv
// Scoreboard bench for the QSPI memory emulator: stimulus pushes expected
// per-rising-edge bus responses, a monitor pops and compares them.
module tb_tb_qspi_mem;

  localparam int               NUM_CS  = 3;
  localparam int               DL      = 16;
  localparam int               DUMMY   = 4;
  localparam int               HALF    = 6;
  localparam logic [2:0]       WR_MASK = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk;
  logic [2:0]  spi_cs_n;
  logic [3:0]  spi_d_in;
  logic [3:0]  spi_d_out;
  logic [3:0]  spi_d_oe;
  logic        ld_en;
  logic [1:0]  ld_bank;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        busy;

  tb_qspi_mem #(
    .NUM_CS(NUM_CS), .DEPTH_LOG2(DL), .DUMMY_NIBBLES(DUMMY), .WRITABLE(WR_MASK)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_d_in(spi_d_in), .spi_d_out(spi_d_out), .spi_d_oe(spi_d_oe),
    .ld_en(ld_en), .ld_bank(ld_bank), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       drive;
    logic [3:0] nib;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model [3][65536];
  int          vectors = 0;
  int          miscompares = 0;

  logic        coll_arm = 1'b0;
  logic [1:0]  coll_bank;
  logic [15:0] coll_addr;
  logic [7:0]  coll_data;

  always @(posedge spi_clk) begin
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_edge: oe=%h dout=%h, no response expected", spi_d_oe, spi_d_out);
    end else begin
      e = exp_q.pop_front();
      if (spi_d_oe !== (e.drive ? 4'hF : 4'h0) || spi_d_out !== (e.drive ? e.nib : 4'h0)) begin
        miscompares++;
        $display("FAIL nibble: got oe=%h dout=%h, required oe=%h dout=%h",
                 spi_d_oe, spi_d_out, (e.drive ? 4'hF : 4'h0), (e.drive ? e.nib : 4'h0));
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic nib(input logic [3:0] n, input logic drive, input logic [3:0] exp_n);
    @(posedge clk); #1 spi_d_in = n;
    repeat (HALF) @(posedge clk);
    #1 exp_q.push_back({drive, exp_n});
    spi_clk = 1'b1;
    if (coll_arm) begin
      // Rising-edge event lands 3 clk later; the bus commit follows on the next edge.
      repeat (3) @(posedge clk);
      #1 ld_en = 1'b1; ld_bank = coll_bank; ld_addr = coll_addr; ld_data = coll_data;
      @(posedge clk);
      #1 ld_en = 1'b0;
      coll_arm = 1'b0;
      repeat (HALF - 4) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1 spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4], 1'b0, 4'h0);
    nib(b[3:0], 1'b0, 4'h0);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a24);
    send_byte(cmd);
    for (int i = 5; i >= 0; i--) nib(a24[i*4 +: 4], 1'b0, 4'h0);
  endtask

  task automatic start_cs(input logic [2:0] csn);
    @(posedge clk); #1 spi_cs_n = csn;
    repeat (4) @(posedge clk);
    #1 check("busy_on", {7'd0, busy}, 8'd1);
  endtask

  task automatic end_cs();
    @(posedge clk); #1 spi_cs_n = 3'b111;
    repeat (6) @(posedge clk);
    #1;
    check("idle_oe", {4'd0, spi_d_oe}, 8'd0);
    check("idle_dout", {4'd0, spi_d_out}, 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
  endtask

  task automatic ld(input int b, input logic [15:0] a, input logic [7:0] v);
    @(posedge clk); #1 ld_en = 1'b1; ld_bank = 2'(b); ld_addr = a; ld_data = v;
    @(posedge clk); #1 ld_en = 1'b0;
    model[b][a] = v;
  endtask

  task automatic do_read(input int b, input logic [23:0] a24, input int n);
    logic [15:0] a;
    logic [7:0]  v;
    a = a24[15:0];
    start_cs(3'(~(3'b001 << b)));
    send_hdr(8'h0B, a24);
    repeat (DUMMY) nib(4'($urandom), 1'b0, 4'h0);
    for (int i = 0; i < n; i++) begin
      v = model[b][a];
      nib(4'($urandom), 1'b1, v[7:4]);
      nib(4'($urandom), 1'b1, v[3:0]);
      a = a + 16'd1;
    end
    end_cs();
  endtask

  task automatic do_write(input int b, input logic [23:0] a24, input logic [7:0] q[$],
                          input int coll_idx, input logic [7:0] coll_val);
    logic [15:0] a;
    a = a24[15:0];
    start_cs(3'(~(3'b001 << b)));
    send_hdr(8'h02, a24);
    for (int i = 0; i < q.size(); i++) begin
      if (WR_MASK[b]) model[b][a] = q[i];
      if (i == coll_idx) begin
        coll_bank = 2'(b); coll_addr = a; coll_data = coll_val;
        model[b][a] = coll_val;
        nib(q[i][7:4], 1'b0, 4'h0);
        coll_arm = 1'b1;
        nib(q[i][3:0], 1'b0, 4'h0);
      end else begin
        send_byte(q[i]);
      end
      a = a + 16'd1;
    end
    end_cs();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] v;
    rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 3'b111; spi_d_in = 4'h0;
    ld_en = 1'b0; ld_bank = 2'd0; ld_addr = 16'd0; ld_data = 8'd0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_oe", {4'd0, spi_d_oe}, 8'd0);
    check("rst_dout", {4'd0, spi_d_out}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Only a window around the wrap point is ever read, so only it is preloaded.
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 32; k++) ld(b, 16'(16'hFFF0 + k), 8'($urandom));

    ld(0, 16'h0000, 8'h13); ld(0, 16'h0001, 8'h57);
    ld(0, 16'h0002, 8'h9B); ld(0, 16'h0003, 8'hDF);
    do_read(0, 24'h000000, 4);

    q = '{8'hA5, 8'h3C};
    do_write(1, 24'h00FFFF, q, -1, 8'h00);
    do_read(1, 24'h00FFFF, 2);

    q = '{8'h55};
    do_write(0, 24'h000000, q, -1, 8'h00);
    do_read(0, 24'h000000, 1);

    start_cs(3'b110);
    send_byte(8'h9F);
    repeat (10) nib(4'($urandom), 1'b0, 4'h0);
    end_cs();
    start_cs(3'b100);
    send_hdr(8'h0B, 24'h000000);
    repeat (12) nib(4'($urandom), 1'b0, 4'h0);
    end_cs();
    do_read(0, 24'h000000, 4);

    start_cs(3'b101);
    send_hdr(8'h02, 24'h000005);
    nib(4'hE, 1'b0, 4'h0);
    end_cs();
    do_read(1, 24'h000005, 1);

    start_cs(3'b110);
    send_hdr(8'h0B, 24'h000000);
    repeat (DUMMY) nib(4'h0, 1'b0, 4'h0);
    v = model[0][0];
    nib(4'h0, 1'b1, v[7:4]);
    nib(4'h0, 1'b1, v[3:0]);
    v = model[0][1];
    nib(4'h0, 1'b1, v[7:4]);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_oe", {4'd0, spi_d_oe}, 8'd0);
    check("midrst_dout", {4'd0, spi_d_out}, 8'd0);
    nib(4'h0, 1'b0, 4'h0);
    nib(4'h0, 1'b0, 4'h0);
    end_cs();
    do_read(0, 24'h000000, 4);

    q = '{8'h11, 8'h22};
    do_write(2, 24'h000003, q, 0, 8'hC7);
    do_read(2, 24'h000003, 2);

    for (int it = 0; it < 20; it++) begin
      int b, off, len, op;
      logic [23:0] a24;
      b   = $urandom_range(0, 2);
      off = $urandom_range(0, 23);
      len = $urandom_range(1, 8);
      op  = $urandom_range(0, 2);
      a24 = {8'($urandom), 16'(16'hFFF0 + off)};
      if (op == 0) begin
        q = {};
        for (int k = 0; k < len; k++) q.push_back(8'($urandom));
        do_write(b, a24, q, -1, 8'h00);
      end else if (op == 1) begin
        ld(b, a24[15:0], 8'($urandom));
      end
      do_read(b, a24, len);
    end

    repeat (10) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d unconsumed responses, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
